// File: rtl/nnue_delta_feeder.sv
// nnue_delta_feeder
// Upstream sequencer for the NNUE accumulator core. Per-move feature deltas
// are buffered in a small FIFO. Each delta is issued to the core with a
// one-cycle trigger pulse, and the sequencer then waits for the core's finish.
// After the delta tagged last, the core's signed evaluation is captured and
// flagged with a one-cycle eval_valid pulse.
//
// Ports
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   d_valid/d_ready     delta handshake; transfer on d_valid & d_ready
//   d_row/d_add/        delta payload: row index, add(1)/subtract(0),
//   d_player/d_last     side to move, and the last-of-move tag
//   nn_trigger          one-cycle start pulse to the core
//   nn_row/nn_add/      operands to the core, held from ISSUE until the
//   nn_player           next entry is popped
//   nn_finish/nn_out    core done flag and its signed evaluation
//   eval_valid/eval     one-cycle update pulse and last captured evaluation
//   busy                FSM not idle or FIFO non-empty
//   level               FIFO occupancy
//   err_timeout         sticky watchdog error, cleared only by reset
module nnue_delta_feeder #(
    parameter int ROW_W   = 7,
    parameter int OUT_W   = 16,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    d_valid,
    output logic                    d_ready,
    input  logic [ROW_W-1:0]        d_row,
    input  logic                    d_add,
    input  logic                    d_player,
    input  logic                    d_last,
    output logic                    nn_trigger,
    output logic [ROW_W-1:0]        nn_row,
    output logic                    nn_add,
    output logic                    nn_player,
    input  logic                    nn_finish,
    input  logic signed [OUT_W-1:0] nn_out,
    output logic                    eval_valid,
    output logic signed [OUT_W-1:0] eval,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    err_timeout
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int EW  = ROW_W + 3;
    localparam int WDW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // FIFO storage and bookkeeping
    logic [EW-1:0]    mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             d_ready_r;

    // sequencer state
    logic [1:0]       state_r;
    logic             busy_r;
    logic [WDW-1:0]   wd_r;
    logic             err_r;

    // issue registers (drive the core directly)
    logic             nn_trigger_r;
    logic [ROW_W-1:0] nn_row_r;
    logic             nn_add_r;
    logic             nn_player_r;
    logic             last_r;

    // evaluation capture
    logic signed [OUT_W-1:0] eval_r;
    logic                    eval_valid_r;

    // next-state terms
    logic             push_s;
    logic             pop_s;
    logic             finish_s;
    logic             expire_s;
    logic [LW-1:0]    level_next_s;
    logic [1:0]       state_next_s;

    // Handshake decode, watchdog expiry, next occupancy and next FSM state.
    always_comb begin
        push_s       = d_valid & d_ready_r;
        pop_s        = (state_r == ST_IDLE) && (level_r != {LW{1'b0}});
        finish_s     = (state_r == ST_WAIT) && nn_finish;
        // the watchdog counts completed WAIT cycles; the TIMEOUT-th one aborts
        expire_s     = (state_r == ST_WAIT) && !nn_finish && (wd_r == WDW'(TIMEOUT - 1));
        level_next_s = level_r;
        state_next_s = state_r;

        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase

        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (finish_s || expire_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FIFO payload storage; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {d_row, d_add, d_player, d_last};
        end
    end

    // FIFO pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            level_r   <= {LW{1'b0}};
            d_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r   <= level_next_s;
            d_ready_r <= (level_next_s != LW'(DEPTH));
        end
    end

    // FSM state and the busy flag, both derived from next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE) || (level_next_s != {LW{1'b0}});
        end
    end

    // Issue registers: loaded on pop and held until the next pop, so the
    // operands stay stable for the whole ISSUE/WAIT window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nn_trigger_r <= 1'b0;
            nn_row_r     <= {ROW_W{1'b0}};
            nn_add_r     <= 1'b0;
            nn_player_r  <= 1'b0;
            last_r       <= 1'b0;
        end else begin
            nn_trigger_r <= pop_s;
            if (pop_s) begin
                {nn_row_r, nn_add_r, nn_player_r, last_r} <= mem_r[rd_ptr_r];
            end
        end
    end

    // Watchdog counter and sticky timeout error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_r  <= {WDW{1'b0}};
            err_r <= 1'b0;
        end else begin
            if (state_r == ST_ISSUE) begin
                wd_r <= {WDW{1'b0}};
            end else if (state_r == ST_WAIT) begin
                wd_r <= wd_r + WDW'(1);
            end else begin
                wd_r <= wd_r;
            end
            if (expire_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Evaluation capture: only a finished last-of-move delta updates eval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_r       <= {OUT_W{1'b0}};
            eval_valid_r <= 1'b0;
        end else begin
            eval_valid_r <= finish_s && last_r;
            if (finish_s && last_r) begin
                eval_r <= nn_out;
            end
        end
    end

    assign d_ready     = d_ready_r;
    assign level       = level_r;
    assign busy        = busy_r;
    assign nn_trigger  = nn_trigger_r;
    assign nn_row      = nn_row_r;
    assign nn_add      = nn_add_r;
    assign nn_player   = nn_player_r;
    assign eval        = eval_r;
    assign eval_valid  = eval_valid_r;
    assign err_timeout = err_r;

endmodule

// File: tb/tb_nnue_delta_feeder.sv
// Self-checking bench for nnue_delta_feeder. A behavioural core model answers
// triggers after a chosen latency; the reference model is the ordered list of
// pushed deltas plus the core answers returned for the deltas tagged last.
module tb_nnue_delta_feeder;

    localparam int ROW_W = 7;
    localparam int OUT_W = 16;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              d_valid  = 1'b0;
    logic [ROW_W-1:0]  d_row    = '0;
    logic              d_add    = 1'b0;
    logic              d_player = 1'b0;
    logic              d_last   = 1'b0;
    logic              sel_t    = 1'b0;
    logic              dv_m, dv_t;
    assign dv_m = d_valid & ~sel_t;
    assign dv_t = d_valid & sel_t;

    // main instance (default TIMEOUT)
    logic d_ready, nn_trigger, nn_add, nn_player, eval_valid, busy, err_timeout;
    logic [ROW_W-1:0] nn_row;
    logic nn_finish = 1'b0;
    logic signed [OUT_W-1:0] nn_out, eval;
    logic [LW-1:0] level;

    // short-timeout instance whose core never finishes
    logic d_ready_t, nn_trigger_t, nn_add_t, nn_player_t, eval_valid_t, busy_t, err_t;
    logic [ROW_W-1:0] nn_row_t;
    logic signed [OUT_W-1:0] eval_t;
    logic [LW-1:0] level_t;

    nnue_delta_feeder #(.ROW_W(ROW_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .TIMEOUT(4096)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(dv_m), .d_ready(d_ready), .d_row(d_row),
        .d_add(d_add), .d_player(d_player), .d_last(d_last), .nn_trigger(nn_trigger),
        .nn_row(nn_row), .nn_add(nn_add), .nn_player(nn_player), .nn_finish(nn_finish),
        .nn_out(nn_out), .eval_valid(eval_valid), .eval(eval), .busy(busy), .level(level),
        .err_timeout(err_timeout));

    nnue_delta_feeder #(.ROW_W(ROW_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .TIMEOUT(16)) dut_to (
        .clk(clk), .rst_n(rst_n), .d_valid(dv_t), .d_ready(d_ready_t), .d_row(d_row),
        .d_add(d_add), .d_player(d_player), .d_last(d_last), .nn_trigger(nn_trigger_t),
        .nn_row(nn_row_t), .nn_add(nn_add_t), .nn_player(nn_player_t), .nn_finish(1'b0),
        .nn_out(16'sd0), .eval_valid(eval_valid_t), .eval(eval_t), .busy(busy_t),
        .level(level_t), .err_timeout(err_t));

    int checks = 0;
    int errors = 0;

    // reference logs
    logic [9:0]  exp_q[$];      // pushed {row,add,player,last}
    logic [8:0]  issued_q[$];   // observed {row,add,player} per trigger
    logic [15:0] out_log[$];    // core answer per completed delta
    logic [15:0] eval_log[$];   // eval value at each eval_valid cycle
    int          trig_cyc[$];
    logic [6:0]  trig_t_rows[$];
    int eval_t_pulses = 0;
    int hold_err = 0;
    int full_seen = 0;
    int full_bad = 0;
    int cyc = 0;

    // core model controls
    bit          pending = 1'b0;
    int          cnt = 0;
    logic [8:0]  held = '0;
    int          core_lat = 4;
    bit          lat_rand = 1'b0;
    bit          core_rand = 1'b0;
    logic signed [15:0] core_val = 16'sd0;

    // Core model and monitor, evaluated on the falling edge.
    initial begin
        nn_out = 16'sd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                pending   = 1'b0;
                nn_finish = 1'b0;
            end else begin
                if (nn_finish) nn_finish = 1'b0;
                if (eval_valid) eval_log.push_back(eval);
                if (eval_valid_t) eval_t_pulses++;
                if (nn_trigger_t) trig_t_rows.push_back(nn_row_t);
                if (nn_trigger) begin
                    held = {nn_row, nn_add, nn_player};
                    issued_q.push_back(held);
                    trig_cyc.push_back(cyc);
                    pending = 1'b1;
                    cnt = lat_rand ? int'($urandom_range(1, 8)) : core_lat;
                end else if (pending) begin
                    if ({nn_row, nn_add, nn_player} !== held) hold_err++;
                    cnt--;
                    if (cnt <= 0) begin
                        nn_out    = core_rand ? 16'($urandom) : core_val;
                        nn_finish = 1'b1;
                        out_log.push_back(nn_out);
                        pending = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    // Offer one delta and wait (bounded) until it is accepted. Starts/ends at negedge.
    task automatic push(input logic [6:0] r, input logic a, input logic p, input logic l);
        int n;
        n = 0;
        d_row = r; d_add = a; d_player = p; d_last = l; d_valid = 1'b1;
        while (((sel_t ? d_ready_t : d_ready) !== 1'b1) && n < 2000) begin
            full_seen++;
            if (!sel_t && level !== LW'(DEPTH)) full_bad++;
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL push_accept d_ready stayed low for %0d cycles", n);
        end else begin
            exp_q.push_back({r, a, p, l});
        end
        @(negedge clk);
        d_valid = 1'b0;
    endtask

    // Bounded wait for the main instance to drain completely.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(busy === 1'b0 && !pending && nn_finish === 1'b0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++; errors++;
            $display("FAIL %s_drain busy=%b still after %0d cycles, required 0", tag, busy, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (d_ready !== 1'b1) begin errors++; $display("FAIL reset_d_ready got %b exp 1", d_ready); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if ({nn_trigger, nn_row, nn_add, nn_player} !== '0) begin
            errors++; $display("FAIL reset_core_if got %b exp 0", {nn_trigger, nn_row, nn_add, nn_player}); end
        checks++; if (eval !== 16'sd0 || eval_valid !== 1'b0) begin
            errors++; $display("FAIL reset_eval got %0d/%b exp 0/0", eval, eval_valid); end
        checks++; if (err_timeout !== 1'b0 || err_t !== 1'b0) begin
            errors++; $display("FAIL reset_err got %b/%b exp 0/0", err_timeout, err_t); end
    endtask

    task automatic test_single();
        int ib, eb;
        ib = issued_q.size(); eb = eval_log.size();
        lat_rand = 1'b0; core_rand = 1'b0; core_lat = 20; core_val = 16'sd123;
        push(7'd0, 1'b1, 1'b1, 1'b1);
        wait_done("single");
        checks++; if (issued_q.size() - ib != 1) begin
            errors++; $display("FAIL single_triggers got %0d exp 1", issued_q.size() - ib); end
        checks++; if (issued_q[ib] !== 9'b0000000_1_1) begin
            errors++; $display("FAIL single_operands got %b exp 000000011", issued_q[ib]); end
        checks++; if (eval_log.size() - eb != 1) begin
            errors++; $display("FAIL single_eval_pulses got %0d exp 1", eval_log.size() - eb); end
        checks++; if (eval !== 16'sd123) begin
            errors++; $display("FAIL single_eval got %0d exp 123", eval); end
    endtask

    task automatic test_move();
        int ib, eb, h0;
        logic [6:0] rows [3];
        ib = issued_q.size(); eb = eval_log.size(); h0 = hold_err;
        rows[0] = 7'd5; rows[1] = 7'd9; rows[2] = 7'd12;
        lat_rand = 1'b0; core_rand = 1'b0; core_lat = 3; core_val = -16'sd42;
        for (int i = 0; i < 3; i++) push(rows[i], 1'($urandom), 1'($urandom), (i == 2) ? 1'b1 : 1'b0);
        wait_done("move");
        for (int i = 0; i < 3; i++) begin
            checks++; if (issued_q[ib+i][8:2] !== rows[i]) begin
                errors++; $display("FAIL move_row%0d got %0d exp %0d", i, issued_q[ib+i][8:2], rows[i]); end
        end
        checks++; if (eval_log.size() - eb != 1) begin
            errors++; $display("FAIL move_eval_pulses got %0d exp 1", eval_log.size() - eb); end
        checks++; if (eval !== -16'sd42) begin
            errors++; $display("FAIL move_eval got %0d exp -42", eval); end
        checks++; if (hold_err != h0) begin
            errors++; $display("FAIL move_hold operand changes during WAIT got %0d exp 0", hold_err - h0); end
    endtask

    task automatic test_burst();
        int ib, eb, ob, xb, nerr;
        logic [15:0] exp_ev[$];
        ib = issued_q.size(); eb = eval_log.size(); ob = out_log.size(); xb = exp_q.size();
        full_seen = 0; full_bad = 0;
        lat_rand = 1'b0; core_rand = 1'b1; core_lat = 6;
        for (int i = 0; i < DEPTH + 2; i++) push(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        wait_done("burst");
        checks++; if (full_seen == 0) begin errors++; $display("FAIL burst_full d_ready never dropped exp drop"); end
        checks++; if (full_bad != 0) begin
            errors++; $display("FAIL burst_full_level d_ready low below DEPTH %0d times exp 0", full_bad); end
        checks++; if (issued_q.size() - ib != DEPTH + 2) begin
            errors++; $display("FAIL burst_triggers got %0d exp %0d", issued_q.size() - ib, DEPTH + 2); end
        nerr = 0;
        for (int i = 0; i < DEPTH + 2; i++) if (issued_q[ib+i] !== exp_q[xb+i][9:1]) nerr++;
        checks++; if (nerr != 0) begin errors++; $display("FAIL burst_order %0d entries differ exp 0", nerr); end
        for (int i = 0; i < DEPTH + 2; i++) if (exp_q[xb+i][0]) exp_ev.push_back(out_log[ob+i]);
        checks++; if (eval_log.size() - eb != exp_ev.size()) begin
            errors++; $display("FAIL burst_eval_pulses got %0d exp %0d", eval_log.size() - eb, exp_ev.size()); end
        nerr = 0;
        foreach (exp_ev[i]) if (eval_log[eb+i] !== exp_ev[i]) nerr++;
        checks++; if (nerr != 0) begin errors++; $display("FAIL burst_eval_values %0d differ exp 0", nerr); end
    endtask

    task automatic test_back_to_back();
        int tb0;
        tb0 = trig_cyc.size();
        lat_rand = 1'b0; core_rand = 1'b1; core_lat = 3;
        for (int i = 0; i < 4; i++) push(7'($urandom), 1'b1, 1'b0, 1'b0);
        wait_done("b2b");
        for (int i = 0; i < 3; i++) begin
            checks++; if (trig_cyc[tb0+i+1] - trig_cyc[tb0+i] != core_lat + 2) begin
                errors++; $display("FAIL b2b_spacing%0d got %0d exp %0d", i,
                                   trig_cyc[tb0+i+1] - trig_cyc[tb0+i], core_lat + 2); end
        end
    endtask

    task automatic test_random();
        int ib, eb, ob, xb, nerr, n;
        logic [15:0] exp_ev[$];
        ib = issued_q.size(); eb = eval_log.size(); ob = out_log.size(); xb = exp_q.size();
        lat_rand = 1'b1; core_rand = 1'b1;
        n = 24;
        for (int i = 0; i < n; i++) begin
            push(7'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_done("random");
        nerr = 0;
        for (int i = 0; i < n; i++) if (issued_q[ib+i] !== exp_q[xb+i][9:1]) nerr++;
        checks++; if (nerr != 0 || issued_q.size() - ib != n) begin
            errors++; $display("FAIL random_order %0d differ, %0d issued exp %0d", nerr, issued_q.size() - ib, n); end
        for (int i = 0; i < n; i++) if (exp_q[xb+i][0]) exp_ev.push_back(out_log[ob+i]);
        nerr = 0;
        foreach (exp_ev[i]) if (eval_log[eb+i] !== exp_ev[i]) nerr++;
        checks++; if (nerr != 0 || eval_log.size() - eb != exp_ev.size()) begin
            errors++; $display("FAIL random_eval %0d differ, %0d pulses exp %0d", nerr,
                               eval_log.size() - eb, exp_ev.size()); end
    endtask

    task automatic test_timeout();
        int n, tb0;
        tb0 = trig_t_rows.size();
        sel_t = 1'b1;
        push(7'd33, 1'b1, 1'b0, 1'b1);
        push(7'd77, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (nn_trigger_t !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL timeout_first_trigger no trigger pulse within 100 cycles exp 1"); end
        repeat (16) @(negedge clk);   // inside the 16th WAIT cycle
        checks++; if (err_t !== 1'b0) begin errors++; $display("FAIL timeout_early got %b exp 0", err_t); end
        @(negedge clk);
        checks++; if (err_t !== 1'b1) begin errors++; $display("FAIL timeout_set got %b exp 1", err_t); end
        n = 0;
        while (nn_trigger_t !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100 || nn_row_t !== 7'd77) begin
            errors++; $display("FAIL timeout_next_issue row %0d exp 77", nn_row_t); end
        repeat (60) @(negedge clk);
        checks++; if (err_t !== 1'b1 || eval_t_pulses != 0) begin
            errors++; $display("FAIL timeout_sticky err %b pulses %0d exp 1/0", err_t, eval_t_pulses); end
        checks++; if (trig_t_rows.size() - tb0 != 2) begin
            errors++; $display("FAIL timeout_triggers got %0d exp 2", trig_t_rows.size() - tb0); end
        sel_t = 1'b0;
    endtask

    task automatic test_midreset();
        int n, ib, glitch;
        lat_rand = 1'b0; core_rand = 1'b0; core_lat = 60; core_val = 16'sd7;
        for (int i = 0; i < 4; i++) push(7'(10 + i), 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (level !== LW'(3)) begin errors++; $display("FAIL midrst_level_before got %0d exp 3", level); end
        rst_n = 1'b0;
        #1;
        checks++; if (level !== '0 || busy !== 1'b0 || nn_trigger !== 1'b0 || d_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_state level %0d busy %b trig %b rdy %b exp 0/0/0/1",
                               level, busy, nn_trigger, d_ready); end
        checks++; if (err_t !== 1'b0 || nn_row !== '0) begin
            errors++; $display("FAIL midrst_clear err_t %b row %0d exp 0/0", err_t, nn_row); end
        glitch = 0;
        for (int i = 0; i < 2; i++) begin @(negedge clk); if (nn_trigger !== 1'b0) glitch++; end
        rst_n = 1'b1;
        ib = issued_q.size();
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (nn_trigger !== 1'b0) glitch++; end
        checks++; if (glitch != 0 || issued_q.size() != ib) begin
            errors++; $display("FAIL midrst_no_trigger got %0d pulses exp 0", glitch); end
        core_lat = 2;
        push(7'd99, 1'b0, 1'b0, 1'b1);
        n = 0;
        wait_done("midrst");
        checks++; if (issued_q.size() - ib != 1 || issued_q[ib][8:2] !== 7'd99) begin
            errors++; $display("FAIL midrst_new_delta issued %0d row %0d exp 1/99",
                               issued_q.size() - ib, issued_q[ib][8:2]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_move();
        test_burst();
        test_back_to_back();
        test_random();
        test_timeout();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
